aes_key_expand_seq: RTL and testbench

Iterative AES-128 key-expansion engine. It sits directly upstream of the pipelined decrypt top level. It accepts one 128-bit cipher key and computes round keys 1..10, one round per clock. It holds all eleven keys stable on registered outputs that drive the decrypt top-level's key and round1..round10 key inputs.

---
 rtl/aes_pkg.sv | 26 ++
 rtl/aes_sbox.sv | 30 +++
 rtl/aes_key_expand_seq.sv | 160 ++++++++++++++++
 tb/tb_aes_key_expand_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared constants, Rcon table, FSM state type and word helpers for the AES-128 key schedule.
package aes_pkg;

  localparam int unsigned KEY_W  = 128;
  localparam int unsigned NR     = 10;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  // Indexed directly by the round counter; entries 0 and 11..15 are never selected.
  localparam logic [BYTE_W-1:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    return {w[WORD_W-BYTE_W-1:0], w[WORD_W-1 -: BYTE_W]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] i_byte,
  output logic [BYTE_W-1:0] o_sub_c
);

  localparam logic [BYTE_W-1:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_sub_c = SBOX[i_byte];

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key expansion: one round key per clock, all eleven keys held on registered outputs.
// Optional macro AES_KEY_ZEROIZE_EN adds a zeroize input that wipes all key material.
module aes_key_expand_seq #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                key_valid,
  input  logic [KEY_W-1:0]    key_in,
  output logic                key_ready,
  output logic                keys_ready,
  output logic [KEY_W-1:0]    key,
  output logic [NR*KEY_W-1:0] round_keys
);

  import aes_pkg::*;

  generate
    if (NR != aes_pkg::NR || KEY_W != aes_pkg::KEY_W) begin : g_cfg_check
      $error("aes_key_expand_seq supports only AES-128 (NR=10, KEY_W=128)");
    end
  endgenerate

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [KEY_W-1:0]     r_w;
  logic [KEY_W-1:0]     r_key;
  logic [NR*KEY_W-1:0]  r_round_keys;
  logic                 r_keys_ready;
  logic                 r_key_ready;

  logic                 w_accept;
  logic                 w_step;
  logic                 w_last;
  logic                 w_zeroize;

  logic [WORD_W-1:0]    w_rot;
  logic [WORD_W-1:0]    w_sub;
  logic [WORD_W-1:0]    w_w0;
  logic [WORD_W-1:0]    w_w1;
  logic [WORD_W-1:0]    w_w2;
  logic [WORD_W-1:0]    w_w3;
  logic [KEY_W-1:0]     w_rk_next;

`ifdef AES_KEY_ZEROIZE_EN
  assign w_zeroize = zeroize;
`else
  assign w_zeroize = 1'b0;
`endif

  // SubWord(RotWord(w3)) via four byte S-boxes
  assign w_rot = rot_word(r_w[WORD_W-1:0]);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte  (w_rot[BYTE_W*g +: BYTE_W]),
      .o_sub_c (w_sub[BYTE_W*g +: BYTE_W])
    );
  end

  // Word chain of one expansion round, fully combinational
  always_comb begin
    w_w0      = r_w[KEY_W-1 -: WORD_W] ^ w_sub ^ {RCON[r_cnt], (WORD_W-BYTE_W)'(0)};
    w_w1      = r_w[KEY_W-WORD_W-1 -: WORD_W] ^ w_w0;
    w_w2      = r_w[KEY_W-2*WORD_W-1 -: WORD_W] ^ w_w1;
    w_w3      = r_w[WORD_W-1:0] ^ w_w2;
    w_rk_next = {w_w0, w_w1, w_w2, w_w3};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus per-cycle control strobes; zeroize overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (key_valid && r_key_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(NR)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_zeroize) begin
      w_state_nxt = IDLE;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_w          <= '0;
      r_key        <= '0;
      r_round_keys <= '0;
      r_keys_ready <= 1'b0;
      r_key_ready  <= 1'b1;
    end else if (w_zeroize) begin
      r_cnt        <= '0;
      r_w          <= '0;
      r_key        <= '0;
      r_round_keys <= '0;
      r_keys_ready <= 1'b0;
      r_key_ready  <= 1'b1;
    end else begin
      if (w_accept) begin
        r_key        <= key_in;
        r_w          <= key_in;
        r_cnt        <= CNT_W'(1);
        r_keys_ready <= 1'b0;
        r_key_ready  <= 1'b0;
      end
      if (w_step) begin
        r_w <= w_rk_next;
        for (int unsigned i = 1; i <= NR; i++) begin
          if (r_cnt == CNT_W'(i)) begin
            r_round_keys[KEY_W*i-1 -: KEY_W] <= w_rk_next;
          end
        end
        // Counter parks at NR so values above it never occur
        if (!w_last) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (w_last) begin
        r_keys_ready <= 1'b1;
        r_key_ready  <= 1'b1;
      end
    end
  end

  assign key_ready  = r_key_ready;
  assign keys_ready = r_keys_ready;
  assign key        = r_key;
  assign round_keys = r_round_keys;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 vectors; define AES_KEY_ZEROIZE_EN to cover zeroize.
module tb_aes_key_expand_seq;

  localparam logic [127:0] K_A1    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_A1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK1_Z   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] RK10_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_valid;
  logic [127:0]  key_in;
  logic          key_ready;
  logic          keys_ready;
  logic [127:0]  key;
  logic [1279:0] round_keys;
`ifdef AES_KEY_ZEROIZE_EN
  logic          zeroize;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_key_expand_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .key_valid  (key_valid),
    .key_in     (key_in),
    .key_ready  (key_ready),
    .keys_ready (keys_ready),
    .key        (key),
    .round_keys (round_keys)
  );

  // One-cycle key offer; returns 1 ns after the accept edge
  task automatic offer_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  // Counts edges until keys_ready, starting from `start`; bounded at 20
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!keys_ready && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (key !== 128'h0) begin n_fail++; $display("FAIL reset_key: got %h want 0", key); end
    n_checks++;
    if (round_keys !== 1280'h0) begin n_fail++; $display("FAIL reset_round_keys: got nonzero want 0"); end
    n_checks++;
    if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL reset_keys_ready: got %b want 0", keys_ready); end
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready: got %b want 1", key_ready); end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fips;
    int cyc;
    offer_key(K_A1);
    n_checks++;
    if (key !== K_A1) begin n_fail++; $display("FAIL fips_key: got %h want %h", key, K_A1); end
    n_checks++;
    if (key_ready !== 1'b0) begin n_fail++; $display("FAIL fips_key_ready_low: got %b want 0", key_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if (round_keys[127:0] !== RK1_A1) begin
      n_fail++; $display("FAIL fips_rk1_latency: got %h want %h", round_keys[127:0], RK1_A1);
    end
    wait_done(1, cyc);
    n_checks++;
    if (cyc != 10) begin n_fail++; $display("FAIL fips_latency: got %0d want 10", cyc); end
    n_checks++;
    if (round_keys[1279:1152] !== RK10_A1) begin
      n_fail++; $display("FAIL fips_rk10: got %h want %h", round_keys[1279:1152], RK10_A1);
    end
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL fips_key_ready_done: got %b want 1", key_ready); end
  endtask

  task automatic test_ignore_during_expand;
    int cyc;
    offer_key(K_A1);
    repeat (4) @(posedge clk);
    #1;
    key_in    = ~K_A1;
    key_valid = 1'b1;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    n_checks++;
    if (key_ready !== 1'b0) begin n_fail++; $display("FAIL ignore_key_ready: got %b want 0", key_ready); end
    wait_done(5, cyc);
    n_checks++;
    if (cyc != 10) begin n_fail++; $display("FAIL ignore_latency: got %0d want 10", cyc); end
    n_checks++;
    if (key !== K_A1) begin n_fail++; $display("FAIL ignore_key: got %h want %h", key, K_A1); end
    n_checks++;
    if (round_keys[127:0] !== RK1_A1) begin
      n_fail++; $display("FAIL ignore_rk1: got %h want %h", round_keys[127:0], RK1_A1);
    end
    n_checks++;
    if (round_keys[1279:1152] !== RK10_A1) begin
      n_fail++; $display("FAIL ignore_rk10: got %h want %h", round_keys[1279:1152], RK10_A1);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (keys_ready !== 1'b1) begin n_fail++; $display("FAIL ignore_done_hold: got %b want 1", keys_ready); end
  endtask

  task automatic test_back_to_back;
    logic [29:0] acc_mask;
    logic [29:0] kr_mask;
    logic        pre;
    int          cyc;
    acc_mask  = '0;
    kr_mask   = '0;
    key_in    = K_A1;
    key_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pre = key_ready;
      @(posedge clk);
      #1;
      acc_mask[i] = pre;
      kr_mask[i]  = keys_ready;
    end
    key_valid = 1'b0;
    n_checks++;
    if (acc_mask !== 30'h0040_0801) begin
      n_fail++; $display("FAIL b2b_accepts: got %h want 00400801", acc_mask);
    end
    n_checks++;
    if (kr_mask !== 30'h0020_0400) begin
      n_fail++; $display("FAIL b2b_keys_ready_pulse: got %h want 00200400", kr_mask);
    end
    wait_done(0, cyc);
    n_checks++;
    if (round_keys[1279:1152] !== RK10_A1) begin
      n_fail++; $display("FAIL b2b_rk10: got %h want %h", round_keys[1279:1152], RK10_A1);
    end
  endtask

  task automatic test_async_reset;
    offer_key(K_A1);
    repeat (6) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (key !== 128'h0) begin n_fail++; $display("FAIL areset_key: got %h want 0", key); end
    n_checks++;
    if (round_keys !== 1280'h0) begin n_fail++; $display("FAIL areset_round_keys: got nonzero want 0"); end
    n_checks++;
    if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL areset_keys_ready: got %b want 0", keys_ready); end
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL areset_key_ready: got %b want 1", key_ready); end
    n_checks++;
    if (round_keys !== 1280'h0) begin n_fail++; $display("FAIL areset_no_partial: got nonzero want 0"); end
  endtask

  task automatic test_zero_key;
    int cyc;
    offer_key(128'h0);
    wait_done(0, cyc);
    n_checks++;
    if (cyc != 10) begin n_fail++; $display("FAIL zero_latency: got %0d want 10", cyc); end
    n_checks++;
    if (round_keys[127:0] !== RK1_Z) begin
      n_fail++; $display("FAIL zero_rk1: got %h want %h", round_keys[127:0], RK1_Z);
    end
    n_checks++;
    if (round_keys[1279:1152] !== RK10_Z) begin
      n_fail++; $display("FAIL zero_rk10: got %h want %h", round_keys[1279:1152], RK10_Z);
    end
  endtask

`ifdef AES_KEY_ZEROIZE_EN
  task automatic test_zeroize;
    int cyc;
    offer_key(K_A1);
    wait_done(0, cyc);
    n_checks++;
    if (keys_ready !== 1'b1) begin n_fail++; $display("FAIL zz_pre_done: got %b want 1", keys_ready); end
    zeroize   = 1'b1;
    key_valid = 1'b1;
    key_in    = K_A1;
    @(posedge clk);
    #1;
    zeroize   = 1'b0;
    key_valid = 1'b0;
    n_checks++;
    if (round_keys !== 1280'h0) begin n_fail++; $display("FAIL zz_round_keys: got nonzero want 0"); end
    n_checks++;
    if (key !== 128'h0) begin n_fail++; $display("FAIL zz_key: got %h want 0", key); end
    n_checks++;
    if (keys_ready !== 1'b0) begin n_fail++; $display("FAIL zz_keys_ready: got %b want 0", keys_ready); end
    n_checks++;
    if (key_ready !== 1'b1) begin n_fail++; $display("FAIL zz_no_accept: got key_ready %b want 1", key_ready); end
    @(posedge clk);
    #1;
    n_checks++;
    if (key_ready !== 1'b1 || key !== 128'h0) begin
      n_fail++; $display("FAIL zz_idle_hold: got key_ready %b key %h want 1 and 0", key_ready, key);
    end
    offer_key(128'h0);
    wait_done(0, cyc);
    n_checks++;
    if (round_keys[127:0] !== RK1_Z) begin
      n_fail++; $display("FAIL zz_rekey_rk1: got %h want %h", round_keys[127:0], RK1_Z);
    end
  endtask
`endif

  initial begin
`ifdef AES_KEY_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    test_reset();
    test_fips();
    test_ignore_during_expand();
    test_back_to_back();
    test_async_reset();
    test_zero_key();
`ifdef AES_KEY_ZEROIZE_EN
    test_zeroize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
